// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: ramOp codes, requester identity and op classification.
package mem_bus_arbiter_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {REQ_IF, REQ_MEM} req_t;

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_lane_align.sv
// Combinational byte-lane logic: byte enables, store lane replication and load extraction.
module mem_lane_align
  import mem_bus_arbiter_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be_n,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be_n      = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (op)
      OP_LB:  begin be_n = ~(4'b0001 << addr_lo); rdata_ext = {{24{sel_byte[7]}}, sel_byte}; end
      OP_LBU: begin be_n = ~(4'b0001 << addr_lo); rdata_ext = {24'd0, sel_byte}; end
      OP_SB:  begin be_n = ~(4'b0001 << addr_lo); wdata_rep = {4{wdata[7:0]}}; end
      OP_LH:  begin be_n = addr_lo[1] ? 4'b0011 : 4'b1100; rdata_ext = {{16{sel_half[15]}}, sel_half}; end
      OP_LHU: begin be_n = addr_lo[1] ? 4'b0011 : 4'b1100; rdata_ext = {16'd0, sel_half}; end
      OP_SH:  begin be_n = addr_lo[1] ? 4'b0011 : 4'b1100; wdata_rep = {2{wdata[15:0]}}; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter and fixed-wait-state sequencer for the shared 32-bit async SRAM.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_success,
  input  logic [3:0]        mem_op,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_success,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_data_oe,
  input  logic [31:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       op_reg;
  logic [1:0]       addr_lo_reg;
  req_t             owner_reg;
  logic [31:0]      rdata_reg;

  logic        grant_mem, grant_if;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [3:0]  align_op;
  logic [1:0]  align_lo;
  logic [3:0]  align_be_n;
  logic [31:0] align_wdata, align_rdata;
  logic        unused_addr_hi;

  // MEM has priority; an IF fetch is always a word read.
  assign grant_mem = (mem_op != OP_NOP);
  assign grant_if  = !grant_mem && if_req;
  assign req_op    = grant_mem ? mem_op : OP_LW;
  assign req_addr  = grant_mem ? mem_addr : if_addr;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // One lane aligner: request values while granting, latched values while accessing.
  assign align_op = (state_reg == ST_IDLE) ? req_op : op_reg;
  assign align_lo = (state_reg == ST_IDLE) ? req_addr[1:0] : addr_lo_reg;

  mem_lane_align u_lane_align (
    .op        (align_op),
    .addr_lo   (align_lo),
    .wdata     (mem_wdata),
    .rdata     (sram_rdata),
    .be_n      (align_be_n),
    .wdata_rep (align_wdata),
    .rdata_ext (align_rdata)
  );

  assign if_rdata  = rdata_reg;
  assign mem_rdata = rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      op_reg       <= OP_NOP;
      addr_lo_reg  <= 2'd0;
      owner_reg    <= REQ_IF;
      rdata_reg    <= 32'd0;
      if_success   <= 1'b0;
      mem_success  <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= 32'd0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'hF;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_mem || grant_if) begin
            state_reg    <= ST_ACCESS;
            owner_reg    <= grant_mem ? REQ_MEM : REQ_IF;
            op_reg       <= req_op;
            addr_lo_reg  <= req_addr[1:0];
            cnt_reg      <= CNT_W'(WAIT_CYCLES - 1);
            sram_addr    <= req_addr[ADDR_W+1:2];
            sram_wdata   <= align_wdata;
            sram_be_n    <= align_be_n;
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= is_store_op(req_op);
            sram_we_n    <= !is_store_op(req_op);
            sram_data_oe <= is_store_op(req_op);
          end
        end
        ST_ACCESS: begin
          if (cnt_reg == '0) begin
            state_reg    <= ST_DONE;
            rdata_reg    <= align_rdata;
            if_success   <= (owner_reg == REQ_IF);
            mem_success  <= (owner_reg == REQ_MEM);
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'hF;
            sram_data_oe <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            // Release we_n for the final access cycle so store data is held past the write edge.
            if (cnt_reg == CNT_W'(1)) sram_we_n <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg   <= ST_IDLE;
          if_success  <= 1'b0;
          mem_success <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expectations queued at issue, popped at each success pulse.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int W  = 2;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic [31:0]   if_rdata;
  logic          if_success;
  logic [3:0]    mem_op;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_success;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic          sram_data_oe;
  logic [31:0]   sram_rdata;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    bit          is_mem;
    bit          chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  mem_bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_success(if_success),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_success(mem_success),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
    .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  wire [7:0] strobes = {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, sram_be_n};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t sb_pop();
    exp_t e;
    e.is_mem = 1'b0; e.chk = 1'b0; e.data = 32'd0;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  // Ticks until the chosen success pulse; n = ticks taken, -1 on timeout (counted as a failure).
  task automatic wait_for(input bit want_mem, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (want_mem ? mem_success : if_success) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      n_cmp++; n_mis++;
      $display("FAIL wait_success: no %s success within 40 cycles", want_mem ? "mem" : "if");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({strobes, sram_addr, sram_wdata} !== {8'hEF, {AW{1'b0}}, 32'd0}) begin
      n_mis++;
      $display("FAIL reset_outputs: got strobes=%h addr=%h wdata=%h, want strobes=ef addr=0 wdata=0",
               strobes, sram_addr, sram_wdata);
    end
    n_cmp++;
    if ({if_success, mem_success, if_rdata, mem_rdata} !== 66'd0) begin
      n_mis++;
      $display("FAIL reset_success: got if_s=%b mem_s=%b if_rd=%h mem_rd=%h, want all zero",
               if_success, mem_success, if_rdata, mem_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  // Issues one MEM op from IDLE and checks every ACCESS cycle, the DONE pulse and the return to IDLE.
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd, input string name);
    bit   st;
    exp_t e, x;
    logic [7:0] want;
    st = is_store_op(op);
    x.is_mem = 1'b1; x.chk = !st; x.data = exp_rd;
    sb.push_back(x);
    mem_op = op; mem_addr = addr; mem_wdata = wd; sram_rdata = rd;
    tick();
    mem_op = OP_NOP;
    for (int c = 0; c < W; c++) begin
      want = {1'b0, st, !(st && c < W - 1), st, exp_be};
      n_cmp++;
      if (strobes !== want || sram_addr !== addr[AW+1:2] || mem_success !== 1'b0) begin
        n_mis++;
        $display("FAIL %s_access%0d: got strobes=%b addr=%h succ=%b, want strobes=%b addr=%h succ=0",
                 name, c, strobes, sram_addr, mem_success, want, addr[AW+1:2]);
      end
      if (st) begin
        n_cmp++;
        if (sram_wdata !== exp_wd) begin
          n_mis++;
          $display("FAIL %s_wdata%0d: got %h, want %h", name, c, sram_wdata, exp_wd);
        end
      end
      tick();
    end
    n_cmp++;
    if (mem_success !== 1'b1 || if_success !== 1'b0 || strobes !== 8'hEF) begin
      n_mis++;
      $display("FAIL %s_done: got mem_s=%b if_s=%b strobes=%b, want mem_s=1 if_s=0 strobes=11101111",
               name, mem_success, if_success, strobes);
    end
    e = sb_pop();
    if (e.chk) begin
      n_cmp++;
      if (mem_rdata !== e.data) begin
        n_mis++;
        $display("FAIL %s_rdata: got %h, want %h", name, mem_rdata, e.data);
      end
    end
    $display("txn %s op=%0d addr=%h be_n=%b rdata=%h", name, op, addr, exp_be, mem_rdata);
    tick();
    n_cmp++;
    if (mem_success !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_pulse_width: got mem_success=%b, want 0", name, mem_success);
    end
  endtask

  task automatic test_loads();
    run_mem(OP_LW,  32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 4'b0000, 32'd0, 32'hDEAD_BEEF, "lw");
    run_mem(OP_LB,  32'h0000_0003, 32'd0, 32'h8012_3456, 4'b0111, 32'd0, 32'hFFFF_FF80, "lb");
    run_mem(OP_LBU, 32'h0000_0003, 32'd0, 32'h8012_3456, 4'b0111, 32'd0, 32'h0000_0080, "lbu");
    run_mem(OP_LHU, 32'h0000_0002, 32'd0, 32'hBEEF_0000, 4'b0011, 32'd0, 32'h0000_BEEF, "lhu");
    run_mem(OP_LH,  32'h0000_0104, 32'd0, 32'h0000_8001, 4'b1100, 32'd0, 32'hFFFF_8001, "lh");
    run_mem(OP_LB,  32'h0000_0021, 32'd0, 32'h0000_7F00, 4'b1101, 32'd0, 32'h0000_007F, "lb_pos");
  endtask

  task automatic test_stores();
    run_mem(OP_SH, 32'h0000_0002, 32'h1234_ABCD, 32'd0, 4'b0011, 32'hABCD_ABCD, 32'd0, "sh");
    run_mem(OP_SB, 32'h0000_0041, 32'h0000_00A5, 32'd0, 4'b1101, 32'hA5A5_A5A5, 32'd0, "sb");
    run_mem(OP_SW, 32'h0000_0808, 32'h1122_3344, 32'd0, 4'b0000, 32'h1122_3344, 32'd0, "sw");
  endtask

  task automatic test_priority();
    exp_t e, x;
    int   n;
    x.is_mem = 1'b1; x.chk = 1'b1; x.data = 32'hA5A5_0001; sb.push_back(x);
    x.is_mem = 1'b0; x.chk = 1'b1; x.data = 32'h0BAD_F00D; sb.push_back(x);
    sram_rdata = 32'hA5A5_0001;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    mem_op = OP_LW; mem_addr = 32'h0000_0040;
    tick();
    mem_op = OP_NOP;
    n_cmp++;
    if (sram_addr !== 20'h00010) begin
      n_mis++;
      $display("FAIL prio_grant_addr: got %h, want 00010", sram_addr);
    end
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      if (mem_success || if_success) begin n = i; break; end
      tick();
    end
    e = sb_pop();
    n_cmp++;
    if (n < 0 || mem_success !== 1'b1 || if_success !== 1'b0 || e.is_mem !== 1'b1 || mem_rdata !== e.data) begin
      n_mis++;
      $display("FAIL prio_mem_first: got mem_s=%b if_s=%b rdata=%h, want mem_s=1 if_s=0 rdata=%h",
               mem_success, if_success, mem_rdata, e.data);
    end
    sram_rdata = 32'h0BAD_F00D;
    wait_for(1'b0, n);
    if_req = 1'b0;
    e = sb_pop();
    n_cmp++;
    if (n !== W + 2 || if_rdata !== e.data || e.is_mem !== 1'b0) begin
      n_mis++;
      $display("FAIL prio_if_after: got gap=%0d rdata=%h, want gap=%0d rdata=%h", n, if_rdata, W + 2, e.data);
    end
    $display("txn prio mem then if gap=%0d if_rdata=%h", n, if_rdata);
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    mem_op = OP_LW; mem_addr = 32'h0000_0080; sram_rdata = 32'h5555_AAAA;
    tick();
    mem_op = OP_NOP;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (strobes !== 8'hEF || sram_addr !== {AW{1'b0}} || mem_success !== 1'b0) begin
      n_mis++;
      $display("FAIL abort_strobes: got strobes=%b addr=%h succ=%b, want strobes=11101111 addr=0 succ=0",
               strobes, sram_addr, mem_success);
    end
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (mem_success || if_success) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_mis++;
      $display("FAIL abort_no_success: got %0d pulses, want 0", seen);
    end
    $display("txn abort lw addr=00000080 pulses=%0d", seen);
    run_mem(OP_LW, 32'h0000_0080, 32'd0, 32'h5555_AAAA, 4'b0000, 32'd0, 32'h5555_AAAA, "reissue");
  endtask

  task automatic test_back_to_back();
    exp_t e, x;
    int   n;
    for (int k = 0; k < 3; k++) begin
      x.is_mem = 1'b0; x.chk = 1'b1; x.data = 32'h1357_9BD0 + 32'(k);
      sb.push_back(x);
    end
    sram_rdata = 32'h1357_9BD0;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      wait_for(1'b0, n);
      if (k == 2) if_req = 1'b0;
      e = sb_pop();
      n_cmp++;
      if (n !== ((k == 0) ? W + 1 : W + 2) || if_rdata !== e.data) begin
        n_mis++;
        $display("FAIL b2b_fetch%0d: got spacing=%0d rdata=%h, want spacing=%0d rdata=%h",
                 k, n, if_rdata, (k == 0) ? W + 1 : W + 2, e.data);
      end
      $display("txn b2b fetch%0d spacing=%0d rdata=%h", k, n, if_rdata);
      sram_rdata = 32'h1357_9BD0 + 32'(k + 1);
    end
    n = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (if_success) n++;
    end
    n_cmp++;
    if (n !== 0) begin
      n_mis++;
      $display("FAIL b2b_stop: got %0d extra fetches, want 0", n);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
    mem_op = OP_NOP; mem_addr = 32'd0; mem_wdata = 32'd0; sram_rdata = 32'd0;
    test_reset();
    test_loads();
    test_stores();
    test_priority();
    test_reset_abort();
    test_back_to_back();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_mis++;
      $display("FAIL scoreboard_empty: got %0d leftover, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequencer and arbiter for the single shared 32-bit asynchronous SRAM. It serves two requesters, instruction fetch (IF) and the MEM stage, and runs a fixed-wait-state access state machine. It generates SRAM strobes and byte enables and returns aligned, extended load data with a one-cycle `*_success` pulse. MEM-stage pause logic and IF stall logic depend on that pulse.

## Interface
Parameters:
- WAIT_CYCLES, 2, number of cycles SRAM strobes are held per access; legal range ≥2.
- ADDR_W, 20, SRAM word-address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  IF word-read request, held until if_success.
- if_addr  in  32  IF byte address (word-aligned).
- if_rdata  out  32  fetched word; valid only while if_success=1.
- if_success  out  1  one-cycle completion pulse to IF.
- mem_op  in  4  MEM ramOp code (NOP/LB/LBU/LH/LHU/LW/SB/SH/SW); non-NOP is a request.
- mem_addr  in  32  MEM byte address.
- mem_wdata  in  32  store data, right-justified.
- mem_rdata  out  32  extended load result; valid only while mem_success=1.
- mem_success  out  1  one-cycle completion pulse to MEM.
- sram_addr  out  ADDR_W  word address, byte address bits [ADDR_W+1:2].
- sram_wdata  out  32  lane-replicated store data.
- sram_data_oe  out  1  drive enable for the external tristate data bus.
- sram_rdata  in  32  SRAM read bus.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.
- sram_be_n  out  4  active-low byte enables.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE:**
  - Arbitrate. If mem_op≠NOP, grant MEM. Otherwise, if if_req=1, grant IF. Otherwise stay in IDLE.
  - On grant, latch the granted requester, op (IF forced to LW), address and wdata. Load the wait counter with WAIT_CYCLES-1. Go to ACCESS.
- **ACCESS:**
  - ce_n=0 and sram_addr/be_n/wdata come from latched values for every ACCESS cycle.
  - Loads: oe_n=0, data_oe=0.
  - Stores: data_oe=1. we_n=0 on every ACCESS cycle except the last, where we_n=1 to give data hold time.
  - Counter decrements each cycle. On counter=0, capture sram_rdata into the read register and go to DONE.
- **DONE:**
  - All strobes inactive.
  - Assert the granted requester's success for exactly one cycle, with rdata driven from the registered value.
  - Next state is IDLE.
- Byte lanes (little-endian, addr[1:0]):
  - LB/LBU/SB: be_n=~(4'b0001<<addr[1:0]).
  - LH/LHU/SH: be_n=addr[1]?4'b0011:4'b1100.
  - LW/SW: 4'b0000.
- Store replication: SB → {4{wdata[7:0]}}; SH → {2{wdata[15:0]}}.
- Load extraction: select the addressed byte or halfword. LB/LH sign-extend; LBU/LHU zero-extend.
- Misalignment is not checked here; MEM already converts faulting ops to NOP. Low address bits are ignored for word ops.
- A request still presented in the IDLE cycle after success is treated as a new request and served again (stalled pipeline replay; stores idempotent).

## Timing
- Request sampled in IDLE at cycle t → ACCESS t+1..t+WAIT_CYCLES → success at t+WAIT_CYCLES+1. Latency is WAIT_CYCLES+1; throughput is one access per WAIT_CYCLES+2 cycles.
- Simultaneous IF and MEM requests: MEM wins. IF is served at the next IDLE in which mem_op=NOP.
- Request changes during ACCESS/DONE are ignored; latched values are used.
- Reset values (including rst asserted mid-access, effective at the next edge):
  - state=IDLE.
  - ce_n=oe_n=we_n=1, be_n=4'hF, data_oe=0.
  - sram_addr=0, sram_wdata=0.
  - both success=0, both rdata=0.
  - An aborted access produces no success pulse.
- All SRAM outputs and success outputs are registered (glitch-free strobes).

## Structure
- ramOp codes (NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8) stay in the shared defines.v.
- Arbiter state encoding is local.
- Sub-module mem_lane_align is combinational. It takes op and addr[1:0] and produces be_n, replicated store data and extended load data.

## Test plan
- MEM LW 0x00000010, WAIT_CYCLES=2, sram_rdata=0xDEADBEEF → sram_addr=0x4, oe_n low 2 cycles, mem_success at t+3, mem_rdata=0xDEADBEEF.
- LB addr 0x3, rdata 0x80xxxxxx → be_n=0111, mem_rdata=0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x2, rdata 0xBEEF0000 → 0x0000BEEF.
- SH addr 0x2, wdata 0x1234ABCD → be_n=0011, sram_wdata=0xABCDABCD, we_n low only in first ACCESS cycle, data_oe high both cycles.
- if_req and mem_op=LW in the same IDLE → MEM served first. IF success follows exactly WAIT_CYCLES+2 cycles after mem_success if mem_op returns to NOP.
- rst asserted in the first ACCESS cycle → next cycle all strobes inactive, be_n=F, no success. Re-issued request completes normally.
- Back-to-back IF fetches held continuously → one if_success every WAIT_CYCLES+2 cycles.
